rng_ctrl: RTL and testbench

RNG_CTRL -- requirements
Module: rng_ctrl

---
 rtl/rng_ctrl_pkg.sv | 35 +++
 rtl/rng_ctrl_arb.sv | 35 +++
 rtl/rng_ctrl.sv | 100 ++++++++++
 tb/tb_rng_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/rng_ctrl_pkg.sv
// Shared types and constants for the RNG request controller.
package rng_ctrl_pkg;

  // Number of requesters sharing the RNG (CPU and debug/aux).
  localparam int NUM_REQ = 2;

  // Width of the random byte and of each requester's mask lane.
  localparam int DATA_W = 8;

  // Default number of free-running cycles between grant and sample.
  localparam int STIR_CYCLES_DEF = 4;

  // Default number of resamples allowed when a sample repeats.
  localparam int MAX_RETRY_DEF = 2;

  // Counter widths sized for the legal parameter ranges (1..15, 0..3).
  localparam int CNT_W   = 4;
  localparam int RETRY_W = 2;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STIR   = 2'd1,
    ST_SAMPLE = 2'd2
  } state_t;

  // Pick the mask lane belonging to requester 'id'.
  function automatic logic [DATA_W-1:0] mask_lane(
    input logic [NUM_REQ*DATA_W-1:0] masks,
    input logic                      id
  );
    return id ? masks[2*DATA_W-1:DATA_W] : masks[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/rng_ctrl_arb.sv
// Two-way round-robin arbiter: one-hot grant from the request vector,
// pointer moves to the losing side after every accepted grant.
module rr_arbiter2
  import rng_ctrl_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  // Preferred requester when both are asking.
  logic ptr;

  // Single requester always wins; on contention the pointer decides.
  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end else begin
      grant = req;
    end
  end

  // After a grant, prefer the other requester next time.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ptr <= 1'b0;
    end else if (advance && (grant != 2'b00)) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/rng_ctrl.sv
// RNG request controller: arbitrates two requesters, lets the RNG stir
// for STIR_CYCLES cycles, samples the free-running byte, rejects a sample
// equal to the last delivered one up to MAX_RETRY times, and returns the
// masked byte to the granted requester.
module rng_ctrl
  import rng_ctrl_pkg::*;
#(
  parameter int STIR_CYCLES = STIR_CYCLES_DEF,
  parameter int MAX_RETRY   = MAX_RETRY_DEF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  rand_bit,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_mask,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        busy
);

  localparam logic [CNT_W-1:0]   CNT_LOAD  = 4'(STIR_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = 2'(MAX_RETRY);

  state_t              state;
  logic [CNT_W-1:0]    stir_cnt;
  logic [RETRY_W-1:0]  retry_cnt;
  logic [DATA_W-1:0]   last_sample;
  logic [DATA_W-1:0]   mask_lat;
  logic                id_lat;
  logic                accept;
  logic                repeat_hit;
  logic [NUM_REQ-1:0]  grant;

  // Grants are only offered while idle and never during reset.
  assign accept     = (state == ST_IDLE) && !rst_in;
  assign req_ready  = accept ? grant : 2'b00;
  assign busy       = (state != ST_IDLE);

  // A sample matching the last delivered byte is redrawn while retries remain.
  assign repeat_hit = (rand_bit == last_sample) && (retry_cnt < RETRY_LIM);

  rr_arbiter2 u_arb (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  // Controller FSM with its counters, the latched request and the response register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= ST_IDLE;
      stir_cnt    <= '0;
      retry_cnt   <= '0;
      last_sample <= 8'h00;
      mask_lat    <= 8'h00;
      id_lat      <= 1'b0;
      rsp_data    <= 8'h00;
      rsp_valid   <= 2'b00;
    end else begin
      rsp_valid <= 2'b00;
      case (state)
        ST_IDLE: begin
          if (req_ready != 2'b00) begin
            id_lat   <= req_ready[1];
            mask_lat <= mask_lane(req_mask, req_ready[1]);
            stir_cnt <= CNT_LOAD;
            state    <= ST_STIR;
          end
        end
        ST_STIR: begin
          if (stir_cnt == '0) begin
            state <= ST_SAMPLE;
          end else begin
            stir_cnt <= stir_cnt - 1'b1;
          end
        end
        ST_SAMPLE: begin
          if (repeat_hit) begin
            retry_cnt <= retry_cnt + 1'b1;
            stir_cnt  <= CNT_LOAD;
            state     <= ST_STIR;
          end else begin
            rsp_data    <= rand_bit & mask_lat;
            rsp_valid   <= id_lat ? 2'b10 : 2'b01;
            last_sample <= rand_bit;
            retry_cnt   <= '0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rng_ctrl.sv
// Directed testbench for rng_ctrl with default parameters (stir 4, retry 2).
module tb_rng_ctrl;

  logic        clk_in;
  logic        rst_in;
  logic [7:0]  rand_bit;
  logic [1:0]  req_valid;
  logic [15:0] req_mask;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        busy;

  int n_asrt;
  int n_fail;
  logic early;

  rng_ctrl dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rand_bit  (rand_bit),
    .req_valid (req_valid),
    .req_mask  (req_mask),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic next();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request in the current cycle, drop it after the grant, and
  // check the response appears exactly 'lat' cycles later and not before.
  task automatic run_req(input string tag, input logic [1:0] rv, input logic [15:0] mk,
                         input logic [7:0] rb, input logic [1:0] exp_g, input int lat,
                         input logic [7:0] exp_d, input int chg_at, input logic [7:0] chg_val);
    req_valid = rv;
    req_mask  = mk;
    rand_bit  = rb;
    #1;
    chk({tag, "_ready"}, {14'd0, req_ready}, {14'd0, exp_g});
    next();
    req_valid = 2'b00;
    early = 1'b0;
    for (int i = 1; i < lat; i++) begin
      if (i == chg_at) rand_bit = chg_val;
      #1;
      if (rsp_valid != 2'b00 || req_ready != 2'b00) early = 1'b1;
      next();
    end
    #1;
    chk({tag, "_rsp_valid"}, {14'd0, rsp_valid}, {14'd0, exp_g});
    chk({tag, "_rsp_data"}, {8'd0, rsp_data}, {8'd0, exp_d});
    chk({tag, "_early"}, {15'd0, early}, 16'd0);
    chk({tag, "_busy_end"}, {15'd0, busy}, 16'd0);
  endtask

  initial begin
    logic [1:0] g_exp;
    logic [7:0] d_exp [4];
    n_asrt = 0;
    n_fail = 0;
    rst_in    = 1'b1;
    rand_bit  = 8'h00;
    req_valid = 2'b11;
    req_mask  = 16'h0000;
    d_exp[0] = 8'h10; d_exp[1] = 8'h10; d_exp[2] = 8'h12; d_exp[3] = 8'h10;

    // Reset state (req_ready must stay low while reset is asserted).
    next();
    next();
    #1;
    chk("rst_ready", {14'd0, req_ready}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_rsp_valid", {14'd0, rsp_valid}, 16'd0);
    chk("rst_rsp_data", {8'd0, rsp_data}, 16'd0);
    rst_in   = 1'b0;
    req_mask = 16'hF0FF;

    // Contention with both requests held: grants alternate, back-to-back.
    for (int k = 0; k < 4; k++) begin
      rand_bit = 8'(8'h10 + k);
      g_exp = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      chk("cont_ready", {14'd0, req_ready}, {14'd0, g_exp});
      next();
      early = 1'b0;
      for (int i = 1; i < 6; i++) begin
        #1;
        if (rsp_valid != 2'b00 || req_ready != 2'b00) early = 1'b1;
        next();
      end
      if (k == 3) req_valid = 2'b00;
      #1;
      chk("cont_rsp_valid", {14'd0, rsp_valid}, {14'd0, g_exp});
      chk("cont_rsp_data", {8'd0, rsp_data}, {8'd0, d_exp[k]});
      chk("cont_early", {15'd0, early}, 16'd0);
    end

    // Single request, full mask, then response held afterwards.
    run_req("single", 2'b01, 16'h00FF, 8'hA5, 2'b01, 6, 8'hA5, 0, 8'h00);
    next();
    #1;
    chk("hold_rsp_valid", {14'd0, rsp_valid}, 16'd0);
    chk("hold_rsp_data", {8'd0, rsp_data}, 16'h00A5);

    // Masking: requester 1 with nibble mask, requester 0 with zero mask.
    run_req("mask0f", 2'b10, 16'h0F00, 8'h3C, 2'b10, 6, 8'h0C, 0, 8'h00);
    run_req("mask00", 2'b01, 16'h0000, 8'h77, 2'b01, 6, 8'h00, 0, 8'h00);

    // Repeat rejection: prime last sample, exhaust retries, then early change.
    run_req("prime5a", 2'b01, 16'h00FF, 8'h5A, 2'b01, 6, 8'h5A, 0, 8'h00);
    run_req("retry2", 2'b01, 16'h00FF, 8'h5A, 2'b01, 16, 8'h5A, 0, 8'h00);
    run_req("retry1", 2'b01, 16'h00FF, 8'h5A, 2'b01, 11, 8'h11, 7, 8'h11);

    // Reset during STIR aborts with no response.
    req_valid = 2'b01;
    req_mask  = 16'h00FF;
    rand_bit  = 8'h99;
    #1;
    chk("rstmid_ready", {14'd0, req_ready}, 16'h0001);
    next();
    req_valid = 2'b00;
    next();
    rst_in = 1'b1;
    #1;
    chk("rstmid_ready_in_rst", {14'd0, req_ready}, 16'd0);
    next();
    rst_in = 1'b0;
    #1;
    chk("rstmid_busy", {15'd0, busy}, 16'd0);
    chk("rstmid_rsp_data", {8'd0, rsp_data}, 16'd0);
    early = 1'b0;
    for (int i = 0; i < 8; i++) begin
      next();
      #1;
      if (rsp_valid != 2'b00) early = 1'b1;
    end
    chk("rstmid_no_rsp", {15'd0, early}, 16'd0);
    // Pointer back to 0: contention grants requester 0 first.
    run_req("rstmid_after", 2'b11, 16'h00FF, 8'h99, 2'b01, 6, 8'h99, 0, 8'h00);

    // Back-to-back: re-request in the response cycle.
    run_req("b2b_first", 2'b01, 16'h00FF, 8'h21, 2'b01, 6, 8'h21, 0, 8'h00);
    run_req("b2b_second", 2'b01, 16'h00FF, 8'h22, 2'b01, 6, 8'h22, 0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
